// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for an 8-bit up/down counter: clear, seek to lo, then ping-pong lo->hi->lo.
// Optional TURN_DWELL_EN macro holds each turnaround for DWELL_CYCLES cycles.
module counter_sweep_ctrl
`ifdef TURN_DWELL_EN
#(
    parameter int DWELL_CYCLES = 4
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_lo,
    input  logic [7:0] cmd_hi,
    input  logic [3:0] cmd_reps,
    input  logic       abort,
    input  logic [7:0] counter_out,
    output logic       cnt_rst,
    output logic       cnt_enable,
    output logic       cnt_direction,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] reps_left
);

    typedef enum logic [2:0] {IDLE, CLEAR, SEEK, UP, DOWN, ABORT} state_t;

    state_t     state, state_nx;
    logic [7:0] lo, hi;
    logic       hit_lo, hit_hi, accept, cmd_ok, turn_ok;

    assign hit_lo = (counter_out == lo);
    assign hit_hi = (counter_out == hi);
    assign accept = cmd_valid && (state == IDLE);
    assign cmd_ok = (cmd_lo < cmd_hi) && (cmd_reps != 4'd0);

`ifdef TURN_DWELL_EN
    // Dwell counter runs while parked on a turnaround target; the hit cycle counts as the first.
    logic [7:0] dwell;
    logic       turn_hold;

    assign turn_hold = (state == UP && hit_hi) || (state == DOWN && hit_lo && reps_left != 4'd1);
    assign turn_ok   = (dwell == 8'(DWELL_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !turn_hold || turn_ok || abort)
            dwell <= 8'd0;
        else
            dwell <= dwell + 8'd1;
    end
`else
    assign turn_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_valid && cmd_ok) state_nx = CLEAR;
            CLEAR:   state_nx = SEEK;
            SEEK:    if (hit_lo) state_nx = UP;
            UP:      if (hit_hi && turn_ok) state_nx = DOWN;
            DOWN: begin
                if (hit_lo) begin
                    if (reps_left == 4'd1)
                        state_nx = IDLE;
                    else if (turn_ok)
                        state_nx = UP;
                end
            end
            ABORT:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Abort wins over any target hit in the same cycle.
        if (abort && state != IDLE && state != ABORT)
            state_nx = ABORT;
    end

    always_comb begin
        cnt_enable    = 1'b0;
        cnt_direction = 1'b1;
        case (state)
            SEEK: cnt_enable = !hit_lo;
            UP:   cnt_enable = !hit_hi;
            DOWN: begin
                cnt_enable    = !hit_lo;
                cnt_direction = 1'b0;
            end
            default: ;
        endcase
    end

    assign cnt_rst   = rst || state == CLEAR || state == ABORT;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            err       <= 1'b0;
            reps_left <= 4'd0;
        end else begin
            done <= (state == DOWN) && (state_nx == IDLE);
            err  <= accept && !cmd_ok;
            if (state_nx == ABORT)
                reps_left <= 4'd0;
            else if (accept && cmd_ok)
                reps_left <= cmd_reps;
            else if (state == DOWN && state_nx != DOWN)
                reps_left <= reps_left - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lo <= cmd_lo;
            hi <= cmd_hi;
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with a behavioural 8-bit up/down counter in the loop.
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_lo = 8'd0;
    logic [7:0] cmd_hi = 8'd0;
    logic [3:0] cmd_reps = 4'd0;
    logic       abort = 1'b0;
    logic [7:0] counter_out = 8'd0;
    logic       cnt_rst, cnt_enable, cnt_direction, busy, done, err;
    logic [3:0] reps_left;

    int vectors = 0;
    int miscompares = 0;

    counter_sweep_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_reps(cmd_reps), .abort(abort),
        .counter_out(counter_out), .cnt_rst(cnt_rst), .cnt_enable(cnt_enable),
        .cnt_direction(cnt_direction), .busy(busy), .done(done), .err(err),
        .reps_left(reps_left)
    );

    always #5 clk = ~clk;

    // The controlled counter: synchronous clear beats enable.
    always @(posedge clk) begin
        if (cnt_rst)
            counter_out <= 8'd0;
        else if (cnt_enable)
            counter_out <= cnt_direction ? counter_out + 8'd1 : counter_out - 8'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] l, input logic [7:0] h, input logic [3:0] r);
        cmd_lo = l; cmd_hi = h; cmd_reps = r; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_cnt [2:13];
        int t;

        // Reset
        step(); step();
        check("rst_cnt_rst", cnt_rst, 1);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_reps", reps_left, 0);
        rst = 1'b0;
        step();
        check("idle_cnt_rst", cnt_rst, 0);

        // lo=2 hi=5 reps=1: done at N+13
        exp_cnt = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd4, 8'd3, 8'd2, 8'd2};
        send(8'd2, 8'd5, 4'd1);
        check("j1_clear", cnt_rst, 1);
        check("j1_reps", reps_left, 1);
        for (int k = 2; k <= 13; k++) begin
            step();
            check($sformatf("j1_cnt_%0d", k), counter_out, exp_cnt[k]);
            check($sformatf("j1_done_%0d", k), done, (k == 13));
            check($sformatf("j1_busy_%0d", k), busy, (k < 13));
            check($sformatf("j1_overshoot_%0d", k),
                  (cnt_enable && cnt_direction && counter_out == 8'd5) ||
                  (cnt_enable && !cnt_direction && counter_out == 8'd2), 0);
        end
        step();
        check("j1_done_drop", done, 0);

        // lo=0 hi=3 reps=2: done at N+19
        send(8'd0, 8'd3, 4'd2);
        check("j2_reps_start", reps_left, 2);
        for (int k = 2; k <= 19; k++) begin
            step();
            if (k == 2) check("j2_seek_en", cnt_enable, 0);
            if (k == 6) check("j2_cnt_top1", counter_out, 3);
            if (k == 10) begin
                check("j2_cnt_bot1", counter_out, 0);
                check("j2_reps_a", reps_left, 2);
            end
            if (k == 11) check("j2_reps_b", reps_left, 1);
            if (k == 14) check("j2_cnt_top2", counter_out, 3);
            check($sformatf("j2_done_%0d", k), done, (k == 19));
        end
        check("j2_reps_end", reps_left, 0);
        check("j2_busy_end", busy, 0);

        // Rejected commands
        send(8'd7, 8'd7, 4'd3);
        check("e1_err", err, 1);
        check("e1_cnt_rst", cnt_rst, 0);
        check("e1_busy", busy, 0);
        step();
        check("e1_err_drop", err, 0);
        send(8'd1, 8'd9, 4'd0);
        check("e2_err", err, 1);
        check("e2_cnt_rst", cnt_rst, 0);
        check("e2_busy", busy, 0);
        check("e2_done", done, 0);
        step();
        check("e2_err_drop", err, 0);
        check("e2_counter", counter_out, 0);

        // Abort mid-UP
        send(8'd10, 8'd200, 4'd1);
        t = 0;
        while (counter_out != 8'd40 && t < 300) begin
            step();
            t++;
        end
        check("ab_reached40", (t < 300), 1);
        check("ab_dir_up", cnt_direction, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_cnt_rst", cnt_rst, 1);
        check("ab_reps", reps_left, 0);
        check("ab_done", done, 0);
        step();
        check("ab_counter", counter_out, 0);
        check("ab_busy", busy, 0);
        check("ab_done2", done, 0);
        check("ab_err", err, 0);

        // Command held while busy, accepted in the done cycle
        send(8'd1, 8'd2, 4'd1);
        cmd_lo = 8'd0; cmd_hi = 8'd1; cmd_reps = 4'd1; cmd_valid = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            check($sformatf("bb_ready_%0d", k), cmd_ready, 0);
            check($sformatf("bb_done_%0d", k), done, 0);
            step();
        end
        check("bb_done", done, 1);
        check("bb_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        check("bb_clear", cnt_rst, 1);
        check("bb_busy", busy, 1);
        check("bb_reps", reps_left, 1);
        for (int k = 2; k <= 7; k++) begin
            step();
            check($sformatf("bb2_done_%0d", k), done, (k == 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer for the 8-bit up/down counter (inputs rst/enable/direction, output counter_out).
- Accepts a sweep command (low bound, high bound, repetition count) over a valid/ready handshake.
- Drives the counter's control pins so it clears, climbs to the low bound, then ping-pongs lo→hi→lo for the requested number of repetitions.
- Reports busy/done/err to the host.

Parameters:
- DWELL_CYCLES, 4, hold cycles at each turnaround; used only when TURN_DWELL_EN is defined.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  high when state==IDLE
- cmd_lo  input  8  sweep low bound
- cmd_hi  input  8  sweep high bound
- cmd_reps  input  4  number of lo→hi→lo sweeps, 1..15
- abort  input  1  cancel the active job
- counter_out  input  8  live value from the counter
- cnt_rst  output  1  counter synchronous reset
- cnt_enable  output  1  counter enable
- cnt_direction  output  1  1=up, 0=down
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at job completion
- err  output  1  one-cycle pulse on a rejected command
- reps_left  output  4  remaining sweeps of the current job

Behaviour:
- Reset values: state=IDLE, done=0, err=0, reps_left=0. Stored lo/hi are don't-care. cnt_rst=1 while rst is high (cnt_rst = rst | state∈{CLEAR,ABORT}).
- Handshake: a command is accepted when cmd_valid & cmd_ready at a rising edge. cmd_lo, cmd_hi and cmd_reps are latched on that edge.
- Validation: cmd_lo>=cmd_hi or cmd_reps==0 → err=1 in the next cycle, state stays IDLE, counter untouched.
- FSM: IDLE → CLEAR → SEEK → UP ↔ DOWN → IDLE. Also any busy state → ABORT → IDLE.
  - CLEAR: one cycle; cnt_rst=1, cnt_enable=0.
  - SEEK: cnt_direction=1, cnt_enable=(counter_out!=lo). When counter_out==lo, go to UP.
  - UP: cnt_direction=1, cnt_enable=(counter_out!=hi). When counter_out==hi, go to DOWN.
  - DOWN: cnt_direction=0, cnt_enable=(counter_out!=lo). When counter_out==lo, decrement reps_left.
    - If reps_left was 1: go to IDLE, done=1 next cycle.
    - Otherwise: go to UP.
- cnt_enable and cnt_direction are combinational from state and counter_out. cnt_enable is never high while counter_out equals the current target, so no overshoot or wrap can occur.
- Turnaround: the cycle in which the target is hit has cnt_enable=0 (one dwell cycle).
- In IDLE and ABORT: cnt_enable=0, cnt_direction=1.
- Latency (lo=L, hi=H, reps=R, accept edge at cycle N):
  - CLEAR at N+1.
  - SEEK occupies L+1 cycles.
  - Each UP and each DOWN occupies (H−L)+1 cycles.
  - done high in cycle N+2+(L+1)+2R(H−L+1).
- abort while busy → ABORT next cycle (cnt_rst=1), then IDLE. No done, no err, reps_left=0. abort in IDLE is ignored.
- Back-to-back jobs: a command may be accepted in the same cycle done is high, since the state is IDLE.
- rst mid-job: IDLE next cycle, outputs at reset values, counter cleared through cnt_rst.
- Simultaneous events: abort has priority over a target hit in the same cycle.

Optional Feature:
- Macro: TURN_DWELL_EN.
- Defined: on each hit of hi (UP→DOWN) and of lo with reps remaining (DOWN→UP), hold for DWELL_CYCLES cycles with cnt_enable=0 before changing direction. SEEK→UP has no dwell. Uses an internal dwell counter; abort is still honoured during a dwell.
- Undefined: single-cycle turnaround as described above. All Test Plan cycle counts assume the macro is undefined.

Test Plan:
- rst=1 for 2 cycles → cnt_rst=1, cmd_ready=1, busy=0, done=0, err=0, reps_left=0.
- lo=2, hi=5, reps=1 accepted at cycle N → counter_out sequence 0,1,2,3,4,5,4,3,2; done high only at N+13; busy low at N+13; no cycle with cnt_enable=1 and counter_out==target.
- lo=0, hi=3, reps=2 → SEEK lasts 1 cycle with cnt_enable=0; counter runs 0..3..0..3..0; reps_left 2→1→0; done at N+19.
- lo=7, hi=7, reps=3, then lo=1, hi=9, reps=0 → err pulse at N+1 each time; cnt_rst stays 0; busy stays 0; no done.
- lo=10, hi=200, reps=1; abort when counter_out==40 in UP → cnt_rst=1 next cycle; counter_out=0 after; busy=0; done never pulses.
- cmd_valid held high with new command while busy → cmd_ready=0, not accepted; accepted in the done cycle; CLEAR follows immediately.
